// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared definitions for the FIFO controller slice: FSM state encodings and
// the default geometry of the register_file the controller drives.
package fifo_ctrl_pkg;

  localparam int ADDR_W_DEF   = 3;
  localparam int DATA_W_DEF   = 4;
  localparam int SCAN_DIV_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENQ  = 2'd1,
    DEQ  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_ctrl_edge_pulse.sv
// edge_pulse
// Converts a level input (a button) into a one-cycle pulse on its rising edge.
// The previous-value register resets to RST_VAL. With RST_VAL=1, a level that
// is held high through reset produces no pulse until it is released and then
// pressed again.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   d     in  level input
//   pulse out d & ~d_prev, high for one cycle per rising edge
module edge_pulse #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_prev;

  always_ff @(posedge clk) begin
    if (rst) d_prev <= RST_VAL;
    else     d_prev <= d;
  end

  assign pulse = d & ~d_prev;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Eight-entry FIFO controller sitting in front of an external register_file.
// Button-level enq/deq requests are reduced to single enqueue/dequeue
// operations; the controller owns pointers, count, full/empty and the
// per-entry valid bits. A free-running scan walks read port 1 over every
// entry to feed the seven-segment display stage.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enq, deq            level requests, acted on at their rising edges
//   in                  data to enqueue (captured when the enqueue is accepted)
//   out                 last dequeued data, registered
//   full, empty, count  occupancy status
//   valid               bit i set while entry i holds live data
//   rf_ra0 / rf_rd0     register_file read port 0, used for dequeue
//   rf_ra1 / rf_rd1     register_file read port 1, used by the display scan
//   rf_wa/rf_we/rf_wd   register_file write port, used for enqueue
//   scan_addr/data/valid entry currently presented to the display
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic                  deq,
  input  logic [DATA_W-1:0]     in,
  output logic [DATA_W-1:0]     out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count,
  output logic [(1<<ADDR_W)-1:0] valid,
  output logic [ADDR_W-1:0]     rf_ra0,
  input  logic [DATA_W-1:0]     rf_rd0,
  output logic [ADDR_W-1:0]     rf_ra1,
  input  logic [DATA_W-1:0]     rf_rd1,
  output logic [ADDR_W-1:0]     rf_wa,
  output logic                  rf_we,
  output logic [DATA_W-1:0]     rf_wd,
  output logic [ADDR_W-1:0]     scan_addr,
  output logic [DATA_W-1:0]     scan_data,
  output logic                  scan_valid
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam int              SCNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCAN_DIV - 1);

  state_t              state, state_nxt;
  logic                enq_p, deq_p;
  logic                accept_enq;
  logic [ADDR_W-1:0]   wp, rp;
  logic [DATA_W-1:0]   in_q;
  logic [SCNT_W-1:0]   scan_cnt;

  edge_pulse #(.RST_VAL(1'b1)) u_enq_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (enq),
    .pulse (enq_p)
  );

  edge_pulse #(.RST_VAL(1'b1)) u_deq_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (deq),
    .pulse (deq_p)
  );

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Enqueue has priority; a dequeue pulse on the same edge is simply dropped.
  assign accept_enq = (state == IDLE) && enq_p && !full;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_enq)           state_nxt = ENQ;
        else if (deq_p && !empty) state_nxt = DEQ;
      end
      ENQ:     state_nxt = IDLE;
      DEQ:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      valid <= '0;
      out   <= '0;
      in_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept_enq) in_q <= in;
      case (state)
        ENQ: begin
          valid[wp] <= 1'b1;
          wp        <= wp + 1'b1;
          count     <= count + 1'b1;
        end
        DEQ: begin
          out       <= rf_rd0;
          valid[rp] <= 1'b0;
          rp        <= rp + 1'b1;
          count     <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The write strobe is gated by rst directly so a reset landing on the
  // ENQ cycle cannot corrupt storage.
  assign rf_we  = (state == ENQ) && !rst;
  assign rf_wa  = wp;
  assign rf_wd  = in_q;
  assign rf_ra0 = rp;

  // Display scan, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_addr <= '0;
    end else if (scan_cnt == SCNT_LAST) begin
      scan_cnt  <= '0;
      scan_addr <= scan_addr + 1'b1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  assign rf_ra1     = scan_addr;
  assign scan_data  = rf_rd1;
  assign scan_valid = valid[scan_addr];

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl
// Directed bench for fifo_ctrl with a behavioural stand-in for register_file
// (synchronous write, combinational reads). SCAN_DIV = 2.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enq, deq;
  logic [3:0] in_d;
  logic [3:0] out;
  logic       full, empty;
  logic [3:0] count;
  logic [7:0] valid;
  logic [2:0] rf_ra0, rf_ra1, rf_wa, scan_addr;
  logic [3:0] rf_rd0, rf_rd1, rf_wd, scan_data;
  logic       rf_we, scan_valid;

  logic [3:0] mem [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;
  assign rf_rd0 = mem[rf_ra0];
  assign rf_rd1 = mem[rf_ra1];

  fifo_ctrl #(.ADDR_W(3), .DATA_W(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .in(in_d), .out(out),
    .full(full), .empty(empty), .count(count), .valid(valid),
    .rf_ra0(rf_ra0), .rf_rd0(rf_rd0), .rf_ra1(rf_ra1), .rf_rd1(rf_rd1),
    .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
    .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid)
  );

  // One enqueue press: request at a negedge, inspect the write port in the
  // ENQ slot one cycle later, then release.
  task automatic press_enq(input logic [3:0] d, input logic exp_we, input logic [2:0] exp_wa);
    @(negedge clk); enq = 1'b1; in_d = d;
    @(negedge clk);
    checks++;
    if (rf_we !== exp_we) begin
      errors++; $display("FAIL enq_we d=%0d: got %b want %b", d, rf_we, exp_we);
    end
    if (exp_we) begin
      checks++;
      if (rf_wa !== exp_wa || rf_wd !== d) begin
        errors++; $display("FAIL enq_port d=%0d: got wa=%0d wd=%0d want wa=%0d wd=%0d", d, rf_wa, rf_wd, exp_wa, d);
      end
    end
    enq = 1'b0;
    @(negedge clk);
  endtask

  // One dequeue press; out is checked once the DEQ cycle has completed.
  task automatic press_deq(input logic [3:0] exp_out, input logic chk_ra, input logic [2:0] exp_ra);
    @(negedge clk); deq = 1'b1;
    @(negedge clk);
    if (chk_ra) begin
      checks++;
      if (rf_ra0 !== exp_ra) begin
        errors++; $display("FAIL deq_ra0: got %0d want %0d", rf_ra0, exp_ra);
      end
    end
    deq = 1'b0;
    @(negedge clk);
    checks++;
    if (out !== exp_out) begin
      errors++; $display("FAIL deq_out: got %0d want %0d", out, exp_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enq = 1'b0; deq = 1'b0; in_d = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
    rst = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 || valid !== 8'h00 || out !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got empty=%b full=%b count=%0d valid=%h out=%0d want 1 0 0 00 0",
               empty, full, count, valid, out);
    end
  endtask

  // Right after reset release: scan_addr advances every 2 cycles.
  task automatic test_scan_step();
    for (int k = 1; k <= 9; k++) begin
      repeat (2) @(negedge clk);
      checks++;
      if (scan_addr !== 3'(k) || rf_ra1 !== 3'(k) || scan_valid !== 1'b0) begin
        errors++;
        $display("FAIL scan_step k=%0d: got addr=%0d ra1=%0d sv=%b want %0d %0d 0",
                 k, scan_addr, rf_ra1, scan_valid, k % 8, k % 8);
      end
    end
  endtask

  task automatic test_enqueue();
    press_enq(4'd5, 1'b1, 3'd0);
    press_enq(4'd6, 1'b1, 3'd1);
    checks++;
    if (count !== 4'd2 || valid !== 8'h03 || empty !== 1'b0) begin
      errors++; $display("FAIL enq_two: got count=%0d valid=%h empty=%b want 2 03 0", count, valid, empty);
    end
  endtask

  // Entries 0 and 1 hold 5 and 6; the scan must show them as live.
  task automatic test_scan_data();
    logic [3:0] exp_d [2];
    exp_d[0] = 4'd5; exp_d[1] = 4'd6;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (scan_addr < 3'd2) begin
        checks++;
        if (scan_valid !== 1'b1 || scan_data !== exp_d[scan_addr[0]]) begin
          errors++; $display("FAIL scan_live a=%0d: got sv=%b d=%0d want 1 %0d",
                             scan_addr, scan_valid, scan_data, exp_d[scan_addr[0]]);
        end
      end else begin
        checks++;
        if (scan_valid !== 1'b0) begin
          errors++; $display("FAIL scan_dead a=%0d: got sv=%b want 0", scan_addr, scan_valid);
        end
      end
    end
  endtask

  task automatic test_dequeue();
    press_deq(4'd5, 1'b1, 3'd0);
    checks++;
    if (count !== 4'd1 || valid !== 8'h02) begin
      errors++; $display("FAIL deq_one: got count=%0d valid=%h want 1 02", count, valid);
    end
    press_deq(4'd6, 1'b1, 3'd1);
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL deq_empty: got empty=%b count=%0d want 1 0", empty, count);
    end
    press_deq(4'd6, 1'b0, 3'd0);
    checks++;
    if (count !== 4'd0 || valid !== 8'h00) begin
      errors++; $display("FAIL deq_on_empty: got count=%0d valid=%h want 0 00", count, valid);
    end
  endtask

  task automatic test_wrap_full();
    for (int i = 0; i < 8; i++) press_enq(4'(i + 1), 1'b1, 3'((i + 2) % 8));
    checks++;
    if (full !== 1'b1 || valid !== 8'hFF || count !== 4'd8 || rf_wa !== 3'd2) begin
      errors++; $display("FAIL fill: got full=%b valid=%h count=%0d wa=%0d want 1 ff 8 2", full, valid, count, rf_wa);
    end
    press_enq(4'd15, 1'b0, 3'd0);
    checks++;
    if (count !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL enq_on_full: got count=%0d full=%b want 8 1", count, full);
    end
    for (int i = 0; i < 8; i++) press_deq(4'(i + 1), 1'b1, 3'((i + 2) % 8));
    checks++;
    if (empty !== 1'b1 || valid !== 8'h00) begin
      errors++; $display("FAIL drain: got empty=%b valid=%h want 1 00", empty, valid);
    end
  endtask

  // rp=wp=2 on entry; after three enqueues, hit enq and deq together.
  task automatic test_back_to_back();
    press_enq(4'd9,  1'b1, 3'd2);
    press_enq(4'd10, 1'b1, 3'd3);
    press_enq(4'd11, 1'b1, 3'd4);
    @(negedge clk); enq = 1'b1; deq = 1'b1; in_d = 4'd12;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 3'd5 || rf_wd !== 4'd12) begin
      errors++; $display("FAIL simul_write: got we=%b wa=%0d wd=%0d want 1 5 12", rf_we, rf_wa, rf_wd);
    end
    enq = 1'b0; deq = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 4'd4 || out !== 4'd8 || valid !== 8'h3C) begin
      errors++; $display("FAIL simul_state: got count=%0d out=%0d valid=%h want 4 8 3c", count, out, valid);
    end
  endtask

  task automatic test_reset_in_enq();
    logic saw_we;
    @(negedge clk); enq = 1'b1; in_d = 4'd3;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_enq_we: got %b want 0", rf_we); end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || valid !== 8'h00 || out !== 4'd0 || rf_wa !== 3'd0 || scan_addr !== 3'd0) begin
      errors++;
      $display("FAIL rst_enq_state: got count=%0d empty=%b valid=%h out=%0d wa=%0d sa=%0d want 0 1 00 0 0 0",
               count, empty, valid, out, rf_wa, scan_addr);
    end
    saw_we = 1'b0;
    repeat (4) begin @(negedge clk); if (rf_we) saw_we = 1'b1; end
    enq = 1'b0;
    repeat (2) begin @(negedge clk); if (rf_we) saw_we = 1'b1; end
    checks++;
    if (saw_we !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL held_enq: got we_seen=%b count=%0d want 0 0", saw_we, count);
    end
    press_enq(4'd7, 1'b1, 3'd0);
    checks++;
    if (count !== 4'd1 || valid !== 8'h01) begin
      errors++; $display("FAIL repress: got count=%0d valid=%h want 1 01", count, valid);
    end
  endtask

  initial begin
    test_reset();
    test_scan_step();
    test_enqueue();
    test_scan_data();
    test_dequeue();
    test_wrap_full();
    test_back_to_back();
    test_reset_in_enq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
